rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
Four-requester round-robin arbiter that shares one downstream resource, for example a single encoder or bus port, between four clients.
- Core: a rotating-priority 4-to-2 encoder; output is a registered one-hot grant plus its 2-bit encoded index.
- A grant is held while its requester keeps req high, up to MAX_HOLD cycles, then is forcibly rotated to prevent starvation.
- Sits between client request lines and the shared-resource select mux.

Parameters:
- MAX_HOLD, 8, max consecutive cycles one grant may be held; 0 disables forced rotation (grant held until release).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- req  input  4  request lines, bit i = requester i, level-sensitive
- grant  output  4  registered one-hot grant; 4'b0000 when idle
- grant_idx  output  2  encoded index of the granted requester; 2'd0 when grant_valid=0
- grant_valid  output  1  high when any grant is active (OR of grant)
- timeout  output  1  one-cycle pulse, high in the first cycle after a forced rotation/regrant caused by MAX_HOLD expiry

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - state=IDLE, ptr=0 (requester 0 highest priority), hold_cnt=0.
  - rst overrides everything, including mid-grant; req is ignored while rst=1.
- Pick function: search req starting at bit ptr, ascending, wrapping 3->0. The first set bit wins; valid = |req.
- State IDLE:
  - At an edge with |req=1: register grant for pick(ptr, req), set hold_cnt=0, go to GRANT.
  - Latency is 1 cycle: req seen at edge k gives grant high from edge k.
  - With |req=0: stay IDLE, outputs 0.
- State GRANT (current index g):
  - Hold: req[g]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD-1). Grant unchanged, hold_cnt++, saturating when MAX_HOLD=0.
  - Release: req[g]=0.
    - ptr<=g+1 (mod 4).
    - If another req is set, grant pick(g+1, req) at the same edge, with no idle bubble.
    - Otherwise go to IDLE with grant=0.
  - Expiry: req[g]=1 and hold_cnt==MAX_HOLD-1, so the grant has been held exactly MAX_HOLD cycles.
    - ptr<=g+1.
    - Grant pick(g+1, req). Requester g is last in that order, so a sole requester regrants to itself.
    - hold_cnt<=0 and timeout<=1 for one cycle.
- The granted requester sees grant for one cycle after dropping req; clients must tolerate this.
- Changes on non-granted req bits during GRANT have no effect until the next release or expiry.
- timeout is 0 in every cycle except the one following an expiry edge.
- hold_cnt width: clog2(MAX_HOLD+1), minimum 1 bit.
- grant, grant_idx and grant_valid are always mutually consistent, all registered, with no combinational path from req.

Decomposition:
- Shared include file:
  - N_REQ=4.
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
- Sub-module rr_pick_4, purely combinational.
  - Inputs: ptr[1:0], req[3:0].
  - Outputs: idx[1:0], valid.
  - Implementation: rotate req right by ptr, fixed-priority 4-to-2 encode (lowest bit wins), add ptr back mod 4.
  - Instantiated once; the top holds only the FSM, ptr, hold_cnt and output registers.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> grant=0000, grant_valid=0, grant_idx=0, timeout=0 throughout; first edge after rst=0 -> grant=0001.
- Single request: req=0010 from cycle 0 -> grant=0010, grant_idx=1 from edge 1; req=0000 at cycle 5 -> grant=0000, grant_valid=0 from edge 6.
- Back-to-back release: grant=0001 active, req=0101; drop req[0] -> next edge grant=0100, grant_idx=2, grant_valid never low, timeout=0.
- Forced rotation (MAX_HOLD=4): req=1111 held -> grant 0001,0010,0100,1000,0001 each for exactly 4 cycles; timeout high in the first cycle of each new grant.
- Sole requester expiry (MAX_HOLD=4): req=1000 only -> grant stays 1000 with grant_valid continuously high; timeout pulses every 4 cycles.
- Reset mid-grant: grant=0100 active, rst=1 one cycle -> grant=0000 next cycle; ptr restored to 0, so with req=1111 the next grant=0001.

Source files
------------

// File: rtl/rr_arbiter_4_pkg.sv
// Shared constants, FSM encoding and helpers for the four-way round-robin arbiter.
package rr_arbiter_4_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } st_e;

    // Rotate right so that bit `s` of the input lands at bit 0.
    function automatic logic [N_REQ-1:0] rotr4(input logic [N_REQ-1:0] v, input logic [1:0] s);
        logic [2*N_REQ-1:0] dbl;
        dbl = {v, v} >> s;
        return dbl[N_REQ-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Client-side request/grant bundle; state_dbg exposes the arbiter FSM state for observation.
// Handshake: req[i] is level-sensitive and held by client i while it wants the resource;
// grant/grant_idx/grant_valid are registered and name the single owner for the current cycle.
interface rr_arbiter_4_if;
    import rr_arbiter_4_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [1:0]       grant_idx;
    logic             grant_valid;
    logic             timeout;
    st_e              state_dbg;

    modport master (
        output req,
        input  grant, grant_idx, grant_valid, timeout, state_dbg
    );

    modport slave (
        input  req,
        output grant, grant_idx, grant_valid, timeout, state_dbg
    );

endinterface

// File: rtl/rr_arbiter_4_pick.sv
// Rotating-priority 4-to-2 encoder: first set req bit at or after ptr, wrapping 3->0.
module rr_pick_4
    import rr_arbiter_4_pkg::*;
(
    input  logic [1:0]       ptr,
    input  logic [N_REQ-1:0] req,
    output logic [1:0]       idx,
    output logic             valid
);

    logic [N_REQ-1:0] rot;
    logic [1:0]       enc;

    always_comb begin
        rot = rotr4(req, ptr);
        enc = 2'd0;
        if (rot[0])      enc = 2'd0;
        else if (rot[1]) enc = 2'd1;
        else if (rot[2]) enc = 2'd2;
        else if (rot[3]) enc = 2'd3;
        // Encoded position is relative to ptr; the mod-4 add falls out of the 2-bit width.
        idx   = enc + ptr;
        valid = |req;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant and optional forced rotation.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic          clk,
    input logic          rst,
    rr_arbiter_4_if.slave bus
);

    localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_SAT  = '1;

    st_e              state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [1:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic [1:0] pick_ptr;
    logic [1:0] pick_idx;
    logic       pick_valid;
    logic       expire;

    // While granting, the search always starts just past the owner so it comes last.
    assign pick_ptr = (state_q == ST_GRANT) ? idx_q + 2'd1 : ptr_q;

    rr_pick_4 u_pick (
        .ptr   (pick_ptr),
        .req   (bus.req),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign expire = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_GRANT;
                    idx_d      = pick_idx;
                    valid_d    = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (!bus.req[idx_q]) begin
                    ptr_d      = idx_q + 2'd1;
                    hold_cnt_d = '0;
                    if (pick_valid) begin
                        idx_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = 2'd0;
                        valid_d = 1'b0;
                    end
                end else if (expire) begin
                    ptr_d      = idx_q + 2'd1;
                    idx_d      = pick_idx;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
                valid_d = 1'b0;
            end
        endcase

        grant_d = valid_d ? (N_REQ'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            idx_q      <= 2'd0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.timeout     = timeout_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: a directed vector table on a MAX_HOLD=4 instance, then random traffic
// on MAX_HOLD=4 and MAX_HOLD=0 instances checked against a behavioural round-robin model.
module tb_rr_arbiter_4;
    import rr_arbiter_4_pkg::*;

    localparam int W = 9;  // {granting, grant[3:0], grant_idx[1:0], grant_valid, timeout}

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;

    int errors   = 0;
    int n_checks = 0;

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];
    vec_t         vecs[$];

    // Behavioural model: owner (-1 = none), priority pointer and cycles the owner has held.
    int m_g[2];
    int m_ptr[2];
    int m_held[2];
    int m_to[2];
    int max_hold[2] = '{4, 0};

    rr_arbiter_4_if if_a ();
    rr_arbiter_4_if if_b ();

    assign if_a.req = req;
    assign if_b.req = req;

    rr_arbiter_4 #(.MAX_HOLD(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    rr_arbiter_4 #(.MAX_HOLD(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int pick(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input int d, input logic r, input logic [3:0] rq);
        m_to[d] = 0;
        if (r) begin
            m_g[d] = -1; m_ptr[d] = 0; m_held[d] = 0;
        end else if (m_g[d] < 0) begin
            m_g[d] = pick(m_ptr[d], rq);
            m_held[d] = 1;
        end else if (!rq[m_g[d]]) begin
            m_ptr[d] = (m_g[d] + 1) % 4;
            m_g[d] = pick(m_ptr[d], rq);
            m_held[d] = 1;
        end else if (max_hold[d] != 0 && m_held[d] == max_hold[d]) begin
            m_ptr[d] = (m_g[d] + 1) % 4;
            m_g[d] = pick(m_ptr[d], rq);
            m_held[d] = 1;
            m_to[d] = 1;
        end else begin
            m_held[d]++;
        end
    endtask

    function automatic logic [W-1:0] model_out(input int d);
        logic [3:0] g;
        logic [1:0] i;
        logic       v;
        v = (m_g[d] >= 0);
        g = v ? (4'b0001 << m_g[d]) : 4'b0000;
        i = v ? 2'(m_g[d]) : 2'd0;
        return {v, g, i, v, 1'(m_to[d])};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic [3:0] rq, output logic [W-1:0] got_a);
        logic [W-1:0] got_b;
        rst = r;
        req = rq;
        @(posedge clk);
        model_step(0, r, rq);
        model_step(1, r, rq);
        exp_a_q.push_back(model_out(0));
        exp_b_q.push_back(model_out(1));
        #1;
        got_a = {logic'(if_a.state_dbg), if_a.grant, if_a.grant_idx, if_a.grant_valid, if_a.timeout};
        got_b = {logic'(if_b.state_dbg), if_b.grant, if_b.grant_idx, if_b.grant_valid, if_b.timeout};
        chk("model_hold4", got_a, exp_a_q.pop_front());
        chk("model_hold0", got_b, exp_b_q.pop_front());
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                       input logic [1:0] i, input logic v, input logic t);
        vec_t x;
        x.rst = r; x.req = rq; x.grant = g; x.idx = i; x.valid = v; x.to = t;
        vecs.push_back(x);
    endtask

    initial begin
        logic [W-1:0] got;
        logic [3:0]   cur_req;
        logic         cur_rst;

        rst = 1'b1;
        req = 4'b0000;
        for (int d = 0; d < 2; d++) begin
            m_g[d] = -1; m_ptr[d] = 0; m_held[d] = 0; m_to[d] = 0;
        end

        // Directed table for the MAX_HOLD=4 instance.
        add(1, 4'b1111, 4'b0000, 2'd0, 0, 0);  // reset with all requests pending
        add(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 0);  // first grant after reset
        for (int k = 0; k < 3; k++) add(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1111, 4'b0010, 2'd1, 1, 1);  // forced rotation
        for (int k = 0; k < 3; k++) add(0, 4'b1111, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b1111, 4'b0100, 2'd2, 1, 1);
        add(0, 4'b1111, 4'b0100, 2'd2, 1, 0);
        add(1, 4'b1111, 4'b0000, 2'd0, 0, 0);  // reset mid-grant
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 0);  // pointer back at 0
        add(0, 4'b0101, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);  // back-to-back handoff, no bubble
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);  // release to idle
        for (int k = 0; k < 4; k++) add(0, 4'b0010, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b0010, 4'b0010, 2'd1, 1, 1);  // sole requester regrants to itself
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) add(0, 4'b1000, 4'b1000, 2'd3, 1, (k > 0 && j == 0) ? 1'b1 : 1'b0);
        end
        add(0, 4'b1000, 4'b1000, 2'd3, 1, 1);

        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].req, got);
            chk($sformatf("vec%0d", n), {1'b0, got[7:0]},
                {1'b0, vecs[n].grant, vecs[n].idx, vecs[n].valid, vecs[n].to});
        end

        // Random traffic: requests mostly persist so holds and expiries occur.
        cur_req = 4'b0000;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) cur_req = 4'($urandom_range(0, 15));
            cur_rst = ($urandom_range(0, 99) == 0);
            step(cur_rst, cur_req, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
